// File: rtl/kr580_pkg.sv
// Shared definitions for the kr580 interrupt controller: register offsets, controller states
// and the channel-mask helper.
package kr580_pkg;

    localparam logic [1:0] INTC_IRR = 2'd0;
    localparam logic [1:0] INTC_IMR = 2'd1;
    localparam logic [1:0] INTC_ISR = 2'd2;
    localparam logic [1:0] INTC_VEC = 2'd3;

    localparam int unsigned VEC_VALID_BIT = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } intc_state_e;

    // Bits [n-1:0] set; used to force unimplemented channels to read 0.
    function automatic logic [7:0] ch_mask(input int unsigned n);
        logic [7:0] m;
        m = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/kr580_intc_if.sv
// CPU port-bus view of the interrupt controller: register window plus the interrupt line.
interface kr580_intc_if;

    logic [7:0] pin_pa;
    logic [7:0] pin_po;
    logic       pin_pw;
    logic [7:0] pin_pi;
    logic       pin_intr;

    modport master (
        output pin_pa,
        output pin_po,
        output pin_pw,
        input  pin_pi,
        input  pin_intr
    );

    modport slave (
        input  pin_pa,
        input  pin_po,
        input  pin_pw,
        output pin_pi,
        output pin_intr
    );

endinterface

// File: rtl/kr580_prio8.sv
// Combinational lowest-index priority encoder over 8 request bits.
module kr580_prio8 (
    input  logic [7:0] req,
    output logic       found,
    output logic [2:0] idx
);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = 3'(i);
            end
        end
    end

endmodule

// File: rtl/kr580_intc.sv
// Interrupt controller for the kr580 port bus: synchronised edge/level requests, mask,
// fixed priority with nested in-service tracking, and a 4-register CPU window.
module kr580_intc
    import kr580_pkg::*;
#(
    parameter int unsigned CHANNELS    = 8,
    parameter logic [7:0]  PORT_BASE   = 8'h80,
    parameter logic [7:0]  EDGE_MASK   = 8'hFF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] irq,
    kr580_intc_if.slave         bus
);

    localparam logic [7:0] CH_MASK = ch_mask(CHANNELS);

    logic [7:0]                    irq_w;
    logic [SYNC_STAGES-1:0][7:0]   sync_q;
    logic [7:0]                    hist_q;
    logic [7:0]                    sync_lvl;
    logic [7:0]                    set_vec;

    logic [7:0] irr_q, irr_d;
    logic [7:0] imr_q, imr_d;
    logic [7:0] isr_q, isr_d;

    logic [7:0] offset;
    logic       in_win;
    logic       wr_irr, wr_imr, wr_isr, wr_vec;

    logic [7:0] eligible;
    logic       e_found, s_found, win_found;
    logic [2:0] e_idx, s_idx;
    logic       ack;

    intc_state_e state_q;
    logic        intr_q;

    always_comb begin
        irq_w                 = '0;
        irq_w[CHANNELS-1:0]   = irq;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= '0;
        end else begin
            if (SYNC_STAGES > 1) begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], irq_w};
            end else begin
                sync_q <= irq_w;
            end
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_lvl = sync_q[SYNC_STAGES-1];
    assign set_vec  = ((EDGE_MASK & sync_lvl & ~hist_q) | (~EDGE_MASK & sync_lvl)) & CH_MASK;

    assign offset = bus.pin_pa - PORT_BASE;
    assign in_win = (offset[7:2] == 6'd0);

    always_comb begin
        wr_irr = 1'b0;
        wr_imr = 1'b0;
        wr_isr = 1'b0;
        wr_vec = 1'b0;
        if (bus.pin_pw && in_win) begin
            unique case (offset[1:0])
                INTC_IRR: wr_irr = 1'b1;
                INTC_IMR: wr_imr = 1'b1;
                INTC_ISR: wr_isr = 1'b1;
                INTC_VEC: wr_vec = 1'b1;
                default:  wr_irr = 1'b0;
            endcase
        end
    end

    assign eligible = irr_q & ~imr_q;

    kr580_prio8 u_prio_elig (
        .req   (eligible),
        .found (e_found),
        .idx   (e_idx)
    );

    kr580_prio8 u_prio_isr (
        .req   (isr_q),
        .found (s_found),
        .idx   (s_idx)
    );

    // Only a request strictly above the highest-priority in-service channel may interrupt.
    assign win_found = e_found && (!s_found || (e_idx < s_idx));
    assign ack       = wr_vec && win_found;

    always_comb begin
        irr_d = irr_q;
        if (wr_irr) irr_d = irr_d & ~bus.pin_po;
        if (ack)    irr_d[e_idx] = 1'b0;
        irr_d = (irr_d | set_vec) & CH_MASK;

        imr_d = imr_q;
        if (wr_imr) imr_d = bus.pin_po & CH_MASK;

        isr_d = isr_q;
        if (wr_isr && s_found) isr_d[s_idx] = 1'b0;
        if (ack)               isr_d[e_idx] = 1'b1;
        isr_d = isr_d & CH_MASK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irr_q <= '0;
            imr_q <= CH_MASK;
            isr_q <= '0;
        end else begin
            irr_q <= irr_d;
            imr_q <= imr_d;
            isr_q <= isr_d;
        end
    end

    // The acknowledged winner is consumed this edge, so the line drops with the ACK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            intr_q  <= 1'b0;
        end else begin
            intr_q <= win_found && !ack;
            unique case (state_q)
                IDLE: begin
                    if (win_found) state_q <= REQ;
                end
                REQ: begin
                    if (ack) begin
                        state_q <= SERVICE;
                    end else if (!win_found) begin
                        state_q <= s_found ? SERVICE : IDLE;
                    end
                end
                SERVICE: begin
                    if (isr_d == 8'd0) state_q <= win_found ? REQ : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.pin_intr = intr_q;

    always_comb begin
        bus.pin_pi = 8'hFF;
        if (in_win) begin
            unique case (offset[1:0])
                INTC_IRR: bus.pin_pi = irr_q;
                INTC_IMR: bus.pin_pi = imr_q;
                INTC_ISR: bus.pin_pi = isr_q;
                INTC_VEC: begin
                    bus.pin_pi = 8'h00;
                    if (win_found) begin
                        bus.pin_pi[VEC_VALID_BIT] = 1'b1;
                        bus.pin_pi[2:0]           = e_idx;
                    end
                end
                default:  bus.pin_pi = 8'hFF;
            endcase
        end
    end

endmodule
